// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
//   Receive-side VGA timing checker. It samples the active-low hsync/vsync
//   pair on the pixel clock, rebuilds the raster position, verifies the
//   stream against the nominal line/frame timing, reports lock and pulses
//   an error on any timing violation.
//
// Ports
//   vgaclk      in   pixel clock, rising edge
//   reset       in   asynchronous, active-high
//   hsync       in   active-low horizontal sync (vgaclk domain)
//   vsync       in   active-low vertical sync (vgaclk domain)
//   x           out  reconstructed column, 0..HMAX-1
//   y           out  reconstructed line,   0..VMAX-1
//   active      out  locked and inside the visible window
//   locked      out  stream verified against nominal timing
//   frame_start out  one-cycle pulse when (x,y) wraps to (0,0)
//   sync_err    out  one-cycle pulse on any timing violation
//
// x/y describe the pixel sampled on the previous edge, so a locked decoder
// reproduces the generator's x/y delayed by exactly one cycle.
`timescale 1ns/1ps

module vga_sync_decoder #(
  parameter logic [9:0]  HBP        = 10'd48,
  parameter logic [9:0]  HACTIVE    = 10'd640,
  parameter logic [9:0]  HFP        = 10'd16,
  parameter logic [9:0]  HSYN       = 10'd96,
  parameter logic [9:0]  HMAX       = HBP + HACTIVE + HFP + HSYN,
  parameter logic [9:0]  VBP        = 10'd32,
  parameter logic [9:0]  VACTIVE    = 10'd480,
  parameter logic [9:0]  VFP        = 10'd11,
  parameter logic [9:0]  VSYN       = 10'd2,
  parameter logic [9:0]  VMAX       = VBP + VACTIVE + VFP + VSYN,
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       locked,
  output logic       frame_start,
  output logic       sync_err
);

  // Column loaded on a falling hsync edge and the columns around the pulse.
  localparam logic [9:0] HFALL_X = HACTIVE + HFP;
  localparam logic [9:0] HPRE_X  = HACTIVE + HFP - 10'd1;
  localparam logic [9:0] HEND_X  = HACTIVE + HFP + HSYN - 10'd1;
  localparam logic [9:0] HLAST_X = HMAX - 10'd1;

  // Line loaded on a falling vsync edge and the line preceding the pulse.
  localparam logic [9:0] VFALL_Y = VACTIVE + VFP;
  localparam logic [9:0] VPRE_Y  = VACTIVE + VFP - 10'd1;
  localparam logic [9:0] VLAST_Y = VMAX - 10'd1;

  localparam int unsigned    GW       = $clog2(LOCK_LINES + 1);
  localparam logic [GW-1:0]  LOCK_CNT = GW'(LOCK_LINES);

  // Previous samples and alignment/qualification state.
  logic          hs_d;
  logic          vs_d;
  logic          h_seen;
  logic          v_seen;
  logic [GW-1:0] h_good;
  logic          v_good;

  // Combinational next-state terms.
  logic       hfall;
  logic       hrise;
  logic       vfall;
  logic       x_last;
  logic       lwrap;
  logic [9:0] x_next;
  logic [9:0] y_next;
  logic       h_err;
  logic       v_err;
  logic       any_err;
  logic       h_ok;
  logic       v_ok;

  always_comb begin
    hfall  = hs_d & ~hsync;
    hrise  = ~hs_d & hsync;
    vfall  = vs_d & ~vsync;
    x_last = (x == HLAST_X);

    // A falling hsync edge reloads x, so it overrides the natural wrap;
    // lwrap therefore means "the next x is 0".
    lwrap  = ~hfall & x_last;

    x_next = x + 10'd1;
    if (hfall) begin
      x_next = HFALL_X;
    end else if (x_last) begin
      x_next = '0;
    end

    y_next = y;
    if (vfall) begin
      y_next = VFALL_Y;
    end else if (lwrap) begin
      y_next = (y == VLAST_Y) ? '0 : y + 10'd1;
    end

    // Checks only run once the matching sync has aligned its counter.
    h_err = h_seen & ((hfall & (x != HPRE_X)) |
                      ((x == HPRE_X) & hsync) |
                      (hrise & (x != HEND_X)));
    v_err = v_seen & ((vfall & (~lwrap | (y != VPRE_Y))) |
                      (lwrap & (y == VPRE_Y) & vsync));
    any_err = h_err | v_err;

    h_ok = h_seen & hfall & (x == HPRE_X);
    v_ok = v_seen & vfall & lwrap & (y == VPRE_Y);
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      x           <= '0;
      y           <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
      hs_d        <= 1'b1;
      vs_d        <= 1'b1;
      h_seen      <= 1'b0;
      v_seen      <= 1'b0;
      h_good      <= '0;
      v_good      <= 1'b0;
    end else begin
      hs_d <= hsync;
      vs_d <= vsync;

      // Counters always follow the edges, even on an error cycle, so the
      // offending edge realigns the raster position.
      x <= x_next;
      y <= y_next;
      if (hfall) h_seen <= 1'b1;
      if (vfall) v_seen <= 1'b1;

      frame_start <= lwrap & (y_next == '0);
      sync_err    <= any_err;

      if (any_err) begin
        h_good <= '0;
        v_good <= 1'b0;
        locked <= 1'b0;
      end else begin
        if (h_ok && (h_good != LOCK_CNT)) h_good <= h_good + GW'(1);
        if (v_ok) v_good <= 1'b1;
        locked <= (h_good == LOCK_CNT) & v_good;
      end
    end
  end

  assign active = locked & (x < HACTIVE) & (y < VACTIVE);

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
Receive-side counterpart of the VGA timing generator. It samples the active-low hsync/vsync pair on the pixel clock, reconstructs the raster position (x, y), and checks the stream against the nominal 800x525 timing. It raises a lock indication once the stream is stable and pulses an error on any timing violation. It is used for loopback self-check of the display path and as the front end of a frame-capture/overlay path.

Parameters:
HBP, 10'd48, horizontal back porch (pixels)
HACTIVE, 10'd640, visible pixels per line
HFP, 10'd16, horizontal front porch
HSYN, 10'd96, hsync pulse width
HMAX, HBP+HACTIVE+HFP+HSYN (800), pixels per line
VBP, 10'd32, vertical back porch (lines)
VACTIVE, 10'd480, visible lines
VFP, 10'd11, vertical front porch
VSYN, 10'd2, vsync pulse width
VMAX, VBP+VACTIVE+VFP+VSYN (525), lines per frame
LOCK_LINES, 4, consecutive good hsync pulses required for horizontal lock

Ports:
vgaclk  input  1  pixel clock; all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
hsync  input  1  active-low horizontal sync, synchronous to vgaclk
vsync  input  1  active-low vertical sync, synchronous to vgaclk
x  output  10  reconstructed column, 0..HMAX-1
y  output  10  reconstructed line, 0..VMAX-1
active  output  1  locked & x<HACTIVE & y<VACTIVE
locked  output  1  stream verified against nominal timing
frame_start  output  1  one-cycle pulse when the (x,y) registers become (0,0)
sync_err  output  1  one-cycle pulse on any timing violation

Behaviour:
- Reset (async): x=0, y=0, locked=0, frame_start=0, sync_err=0. Internal state also clears: hs_d=1, vs_d=1 (previous samples), h_seen=0, v_seen=0, h_good=0, v_good=0.
- Edge detection at each clock edge, using the current input sample against the previous registered sample:
  - hfall = hs_d & ~hsync
  - hrise = ~hs_d & hsync
  - vfall = vs_d & ~vsync
  - vs_d and hs_d update every cycle.
- Latency: x/y describe the pixel sampled on the previous edge. When locked, x/y equal the generator's x/y delayed exactly one cycle.
- X counter, priority order:
  1. hfall: x <= HACTIVE+HFP (656); h_seen <= 1.
  2. Otherwise, x==HMAX-1: x <= 0.
  3. Otherwise: x <= x+1.
- Line wrap (lwrap) is the condition "next x == 0". Before the first hfall, x free-runs from 0.
- Y counter, priority order:
  1. vfall: y <= VACTIVE+VFP (491); v_seen <= 1.
  2. Otherwise, on lwrap: y <= (y==VMAX-1) ? 0 : y+1.
  3. Otherwise: hold.
- Horizontal checks, active only when h_seen=1. Each is an error:
  - hfall while x != 655.
  - x==655 while hsync=1 (missing pulse).
  - hrise while x != HACTIVE+HFP+HSYN-1 (751) (wrong width).
  - A good hfall increments h_good, saturating at LOCK_LINES.
- Vertical checks, active only when v_seen=1. Each is an error:
  - vfall while not lwrap.
  - vfall while y != 490.
  - lwrap with y==490 while vsync=1 (missing pulse).
  - A good vfall sets v_good=1.
- The first hfall and the first vfall after reset or error only align the counters; they are never checked.
- Lock: locked <= (h_good==LOCK_LINES) & v_good, registered. Lock first asserts one cycle after the second vsync fall from reset.
- On error:
  - sync_err pulses once, even if several checks fail in the same cycle.
  - h_good=0, v_good=0, locked=0.
  - h_seen and v_seen are kept, so counters realign on the offending edge (the load still happens).
- Error cycles: sync_err and the locked drop both appear the cycle after the offending sample.
- frame_start: registered pulse, high in the cycle where x==0 and y==0 after a wrap. Never asserts from reset state alone.
- Widths: all comparisons use 10-bit unsigned arithmetic. Counters never exceed HMAX-1 / VMAX-1.
- Reset mid-frame: immediate clear; re-lock requires the full sequence again.

Test Plan:
- Nominal: feed ideal 800x525 hsync/vsync starting at arbitrary phase (x=300,y=100) -> x=656 the cycle after first hfall; locked=1 one cycle after second vfall; x/y equal generator x/y delayed 1; sync_err never asserts over 3 frames.
- Active/frame_start: locked stream -> active=1 exactly for x 0..639, y 0..479 (307200 cycles/frame); frame_start pulses once per 420000 cycles.
- Short line: while locked, make one line 799 pixels -> sync_err pulses once; locked=0; x=656 after that edge; re-lock after 4 good lines plus next good vfall.
- Wrong width: hsync low for 95 cycles -> sync_err on the rise (x=750 at detection); locked drops.
- Missing vsync: suppress one vsync pulse -> sync_err when y=490 at line wrap; y continues to 491; next frame's good vfall restores v_good.
- Async reset mid-line at x=400: outputs clear with no clock edge; x resumes from 0; locked=0 until full re-lock.
